// File: rtl/tone_sequencer_if.sv
// Note-request handshake between a note source and the tone sequencer.
interface tone_sequencer_if;
  logic       note_valid;
  logic       note_ready;
  logic [3:0] note_code;
  logic [1:0] note_octave;
  logic [7:0] note_len;

  modport master (
    output note_valid, note_code, note_octave, note_len,
    input  note_ready
  );

  modport slave (
    input  note_valid, note_code, note_octave, note_len,
    output note_ready
  );
endinterface

// File: rtl/tone_sequencer.sv
// Note scheduler: 4-deep note queue feeding a square-wave player with a
// fixed silent gap after every note.
module tone_sequencer #(
  parameter int unsigned TICK_DIV   = 8000,
  parameter int unsigned GAP_TICKS  = 20,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  tone_sequencer_if.slave     req,
  input  logic                flush,
  output logic                tone_out,
  output logic                playing,
  output logic                busy,
  output logic [2:0]          fifo_count,
  output logic [3:0]          cur_code
);

  localparam int unsigned PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [7:0]    GAP8      = 8'(GAP_TICKS);
  localparam logic [2:0]    FULL      = 3'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  state_t        state;
  logic [13:0]   mem [4];
  logic [1:0]    wr_ptr;
  logic [1:0]    rd_ptr;
  logic [2:0]    count;
  logic [15:0]   half_reg;
  logic [15:0]   half_cnt;
  logic [PW-1:0] presc;
  logic [7:0]    ticks;
  logic          push;
  logic          pop;
  logic          tick;
  logic          cur_rest;
  logic [3:0]    head_code;
  logic [1:0]    head_oct;
  logic [7:0]    head_len;
  logic [15:0]   head_half;

  // Half-period in clocks for a chromatic code, shifted down by octave.
  function automatic logic [15:0] half_of(input logic [3:0] code, input logic [1:0] oct);
    logic [15:0] base;
    case (code)
      4'd0:    base = 16'd15289;
      4'd1:    base = 16'd14431;
      4'd2:    base = 16'd13621;
      4'd3:    base = 16'd12856;
      4'd4:    base = 16'd12135;
      4'd5:    base = 16'd11454;
      4'd6:    base = 16'd10811;
      4'd7:    base = 16'd10204;
      4'd8:    base = 16'd9631;
      4'd9:    base = 16'd9091;
      4'd10:   base = 16'd8581;
      4'd11:   base = 16'd8099;
      default: base = 16'd1;
    endcase
    return base >> oct;
  endfunction

  assign req.note_ready = (count != FULL) && !flush;
  assign push      = req.note_valid && req.note_ready;
  // Pop only looks at the registered count, so a note never bypasses an empty queue.
  assign pop       = (state == IDLE) && (count != 3'd0) && !flush;
  assign tick      = (presc == TICK_LAST);
  assign cur_rest  = &cur_code[3:2];
  assign head_code = mem[rd_ptr][13:10];
  assign head_oct  = mem[rd_ptr][9:8];
  assign head_len  = mem[rd_ptr][7:0];
  assign head_half = half_of(head_code, head_oct);

  assign playing    = (state == PLAY);
  assign busy       = (state != IDLE) || (count != 3'd0);
  assign fifo_count = count;

  // Queue storage; entries need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {req.note_code, req.note_octave, req.note_len};
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b0, push} - {2'b0, pop};
    end
  end

  // Player FSM: load from queue, play square wave for len ticks, then gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tone_out <= 1'b0;
      cur_code <= '0;
      half_reg <= '0;
      half_cnt <= '0;
      presc    <= '0;
      ticks    <= '0;
    end else if (flush) begin
      state    <= IDLE;
      tone_out <= 1'b0;
      cur_code <= '0;
      half_reg <= '0;
      half_cnt <= '0;
      presc    <= '0;
      ticks    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (count != 3'd0) begin
            cur_code <= head_code;
            half_reg <= head_half;
            half_cnt <= head_half - 16'd1;
            presc    <= '0;
            if (head_len != 8'd0) begin
              state    <= PLAY;
              ticks    <= head_len;
              tone_out <= !(&head_code[3:2]);
            end else if (GAP_TICKS != 0) begin
              state <= GAP;
              ticks <= GAP8;
            end else begin
              cur_code <= '0;
              half_cnt <= '0;
            end
          end
        end
        PLAY: begin
          presc <= tick ? '0 : presc + PW'(1);
          if (half_cnt == 16'd0) begin
            half_cnt <= half_reg - 16'd1;
            if (!cur_rest) tone_out <= ~tone_out;
          end else begin
            half_cnt <= half_cnt - 16'd1;
          end
          if (tick) begin
            if (ticks == 8'd1) begin
              tone_out <= 1'b0;
              half_cnt <= '0;
              presc    <= '0;
              if (GAP_TICKS != 0) begin
                state <= GAP;
                ticks <= GAP8;
              end else begin
                state    <= IDLE;
                ticks    <= '0;
                cur_code <= '0;
              end
            end else begin
              ticks <= ticks - 8'd1;
            end
          end
        end
        GAP: begin
          presc <= tick ? '0 : presc + PW'(1);
          if (tick) begin
            if (ticks == 8'd1) begin
              state    <= IDLE;
              presc    <= '0;
              ticks    <= '0;
              cur_code <= '0;
            end else begin
              ticks <= ticks - 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer: one DUT with a 2-tick gap, one with no gap.
module tb_tone_sequencer;
  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       tone_out, playing, busy;
  logic [2:0] fifo_count;
  logic [3:0] cur_code;
  logic       tone2, playing2, busy2;
  logic [2:0] count2;
  logic [3:0] code2;
  int         total;
  int         passed;

  tone_sequencer_if bus();
  tone_sequencer_if bus2();

  tone_sequencer #(.TICK_DIV(100), .GAP_TICKS(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(bus), .flush(flush),
    .tone_out(tone_out), .playing(playing), .busy(busy),
    .fifo_count(fifo_count), .cur_code(cur_code)
  );

  tone_sequencer #(.TICK_DIV(100), .GAP_TICKS(0)) dut_nogap (
    .clk(clk), .rst_n(rst_n), .req(bus2), .flush(1'b0),
    .tone_out(tone2), .playing(playing2), .busy(busy2),
    .fifo_count(count2), .cur_code(code2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    #12;
    total++; if (tone_out !== 1'b0) $display("FAIL reset_tone: got %b want 0", tone_out); else passed++;
    total++; if (playing !== 1'b0) $display("FAIL reset_playing: got %b want 0", playing); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    total++; if (fifo_count !== 3'd0) $display("FAIL reset_count: got %0d want 0", fifo_count); else passed++;
    total++; if (cur_code !== 4'd0) $display("FAIL reset_code: got %0d want 0", cur_code); else passed++;
    total++; if (bus.note_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.note_ready); else passed++;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_single_note();
    int n, g, bad;
    @(negedge clk);
    bus.note_valid = 1'b1; bus.note_code = 4'd9; bus.note_octave = 2'd3; bus.note_len = 8'd10;
    @(posedge clk); @(negedge clk);
    bus.note_valid = 1'b0;
    total++; if (playing !== 1'b0) $display("FAIL single_early_play: got %b want 0", playing); else passed++;
    total++; if (fifo_count !== 3'd1) $display("FAIL single_queued: got %0d want 1", fifo_count); else passed++;
    @(negedge clk);
    total++; if (playing !== 1'b1) $display("FAIL single_enter_play: got %b want 1", playing); else passed++;
    total++; if (cur_code !== 4'd9) $display("FAIL single_cur_code: got %0d want 9", cur_code); else passed++;
    n = 0; bad = 0;
    while (playing === 1'b1 && n < 5000) begin
      n++; if (tone_out !== 1'b1) bad++;
      @(negedge clk);
    end
    total++; if (n != 1000) $display("FAIL single_play_len: got %0d want 1000", n); else passed++;
    total++; if (bad != 0) $display("FAIL single_tone_high: got %0d low cycles want 0", bad); else passed++;
    g = 0; bad = 0;
    while (busy === 1'b1 && playing === 1'b0 && g < 5000) begin
      g++; if (tone_out !== 1'b0) bad++;
      @(negedge clk);
    end
    total++; if (g != 200) $display("FAIL single_gap_len: got %0d want 200", g); else passed++;
    total++; if (bad != 0) $display("FAIL single_gap_silent: got %0d high cycles want 0", bad); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL single_idle_busy: got %b want 0", busy); else passed++;
    total++; if (cur_code !== 4'd0) $display("FAIL single_idle_code: got %0d want 0", cur_code); else passed++;
  endtask

  task automatic test_rest();
    int n, bad, badc, w;
    @(negedge clk);
    bus.note_valid = 1'b1; bus.note_code = 4'd15; bus.note_octave = 2'd0; bus.note_len = 8'd5;
    @(posedge clk); @(negedge clk);
    bus.note_valid = 1'b0;
    @(negedge clk);
    n = 0; bad = 0; badc = 0;
    while (playing === 1'b1 && n < 5000) begin
      n++;
      if (tone_out !== 1'b0) bad++;
      if (cur_code !== 4'd15) badc++;
      @(negedge clk);
    end
    total++; if (n != 500) $display("FAIL rest_play_len: got %0d want 500", n); else passed++;
    total++; if (bad != 0) $display("FAIL rest_silent: got %0d high cycles want 0", bad); else passed++;
    total++; if (badc != 0) $display("FAIL rest_cur_code: got %0d wrong cycles want 0", badc); else passed++;
    w = 0;
    while (busy === 1'b1 && w < 5000) begin w++; @(negedge clk); end
    total++; if (busy !== 1'b0) $display("FAIL rest_drain: busy got %b want 0", busy); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] codes [5];
    int h, l, w, idle_n;
    codes[0] = 4'd1; codes[1] = 4'd12; codes[2] = 4'd4; codes[3] = 4'd6; codes[4] = 4'd7;
    @(negedge clk);
    bus.note_valid = 1'b1; bus.note_code = 4'd9; bus.note_octave = 2'd3; bus.note_len = 8'd255;
    @(posedge clk); @(negedge clk);
    bus.note_valid = 1'b0;
    @(negedge clk);
    h = 0;
    while (tone_out === 1'b1 && h < 5000) begin h++; @(negedge clk); end
    l = 0;
    while (tone_out === 1'b0 && playing === 1'b1 && l < 5000) begin l++; @(negedge clk); end
    total++; if (h != 1136) $display("FAIL b2b_half_high: got %0d want 1136", h); else passed++;
    total++; if (l != 1136) $display("FAIL b2b_half_low: got %0d want 1136", l); else passed++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.note_valid = 1'b1; bus.note_code = codes[i]; bus.note_octave = 2'd0; bus.note_len = 8'd1;
      total++; if (bus.note_ready !== 1'b1) $display("FAIL b2b_accept%0d: ready got %b want 1", i, bus.note_ready); else passed++;
      @(posedge clk);
    end
    @(negedge clk);
    bus.note_code = codes[4];
    total++; if (fifo_count !== 3'd4) $display("FAIL b2b_full_count: got %0d want 4", fifo_count); else passed++;
    total++; if (bus.note_ready !== 1'b0) $display("FAIL b2b_fifth_ready: got %b want 0", bus.note_ready); else passed++;
    w = 0; idle_n = 0;
    while (bus.note_ready !== 1'b1 && w < 30000) begin
      if (playing === 1'b0) idle_n++;
      @(negedge clk); w++;
    end
    total++; if (bus.note_ready !== 1'b1) $display("FAIL b2b_fifth_wait: ready got %b want 1", bus.note_ready); else passed++;
    total++; if (idle_n != 201) $display("FAIL b2b_gap_then_pop: got %0d idle cycles want 201", idle_n); else passed++;
    total++; if (fifo_count !== 3'd3) $display("FAIL b2b_after_pop: got %0d want 3", fifo_count); else passed++;
    total++; if (cur_code !== 4'd1) $display("FAIL b2b_head_order: got %0d want 1", cur_code); else passed++;
    @(posedge clk); @(negedge clk);
    bus.note_valid = 1'b0;
    total++; if (fifo_count !== 3'd4) $display("FAIL b2b_fifth_pushed: got %0d want 4", fifo_count); else passed++;
    w = 0;
    while (busy === 1'b1 && w < 10000) begin w++; @(negedge clk); end
    total++; if (busy !== 1'b0) $display("FAIL b2b_drain: busy got %b want 0", busy); else passed++;
  endtask

  task automatic test_flush();
    @(negedge clk);
    bus.note_valid = 1'b1; bus.note_code = 4'd2; bus.note_octave = 2'd0; bus.note_len = 8'd50;
    @(posedge clk); @(negedge clk);
    bus.note_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      bus.note_valid = 1'b1; bus.note_code = 4'(3 + i); bus.note_len = 8'd3;
      @(posedge clk); @(negedge clk);
    end
    bus.note_valid = 1'b0;
    repeat (5) @(negedge clk);
    total++; if (fifo_count !== 3'd3) $display("FAIL flush_pre_count: got %0d want 3", fifo_count); else passed++;
    total++; if (tone_out !== 1'b1) $display("FAIL flush_pre_tone: got %b want 1", tone_out); else passed++;
    flush = 1'b1; bus.note_valid = 1'b1; bus.note_code = 4'd5; bus.note_len = 8'd3;
    #1;
    total++; if (bus.note_ready !== 1'b0) $display("FAIL flush_ready: got %b want 0", bus.note_ready); else passed++;
    @(posedge clk); #1;
    total++; if (tone_out !== 1'b0) $display("FAIL flush_tone: got %b want 0", tone_out); else passed++;
    total++; if (playing !== 1'b0) $display("FAIL flush_playing: got %b want 0", playing); else passed++;
    total++; if (fifo_count !== 3'd0) $display("FAIL flush_count: got %0d want 0", fifo_count); else passed++;
    total++; if (cur_code !== 4'd0) $display("FAIL flush_code: got %0d want 0", cur_code); else passed++;
    @(negedge clk);
    flush = 1'b0; bus.note_valid = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL flush_idle: busy got %b want 0", busy); else passed++;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus.note_valid = 1'b1; bus.note_code = 4'd2; bus.note_octave = 2'd0; bus.note_len = 8'd50;
    @(posedge clk); @(negedge clk);
    bus.note_code = 4'd3; bus.note_len = 8'd4;
    @(posedge clk); @(negedge clk);
    bus.note_code = 4'd4;
    @(posedge clk); @(negedge clk);
    bus.note_valid = 1'b0;
    total++; if (playing !== 1'b1 || tone_out !== 1'b1) $display("FAIL arst_pre: playing/tone got %b%b want 11", playing, tone_out); else passed++;
    total++; if (fifo_count !== 3'd2) $display("FAIL arst_pre_count: got %0d want 2", fifo_count); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (tone_out !== 1'b0) $display("FAIL arst_tone: got %b want 0", tone_out); else passed++;
    total++; if (playing !== 1'b0) $display("FAIL arst_playing: got %b want 0", playing); else passed++;
    total++; if (fifo_count !== 3'd0) $display("FAIL arst_count: got %0d want 0", fifo_count); else passed++;
    total++; if (bus.note_ready !== 1'b1) $display("FAIL arst_ready: got %b want 1", bus.note_ready); else passed++;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL arst_after: busy got %b want 0", busy); else passed++;
  endtask

  task automatic test_no_gap();
    int n, bad;
    @(negedge clk);
    bus2.note_valid = 1'b1; bus2.note_code = 4'd3; bus2.note_octave = 2'd0; bus2.note_len = 8'd0;
    @(posedge clk); @(negedge clk);
    bus2.note_code = 4'd0; bus2.note_len = 8'd1;
    @(posedge clk); @(negedge clk);
    bus2.note_valid = 1'b0;
    total++; if (playing2 !== 1'b0 || tone2 !== 1'b0) $display("FAIL nogap_zero_len: playing/tone got %b%b want 00", playing2, tone2); else passed++;
    total++; if (count2 !== 3'd1 || busy2 !== 1'b1) $display("FAIL nogap_second_queued: count/busy got %0d/%b want 1/1", count2, busy2); else passed++;
    @(negedge clk);
    total++; if (tone2 !== 1'b1 || playing2 !== 1'b1) $display("FAIL nogap_rise: tone/playing got %b%b want 11", tone2, playing2); else passed++;
    total++; if (code2 !== 4'd0 || count2 !== 3'd0) $display("FAIL nogap_code: code/count got %0d/%0d want 0/0", code2, count2); else passed++;
    n = 0; bad = 0;
    while (playing2 === 1'b1 && n < 5000) begin
      n++; if (tone2 !== 1'b1) bad++;
      @(negedge clk);
    end
    total++; if (n != 100 || bad != 0) $display("FAIL nogap_play: len/lowcycles got %0d/%0d want 100/0", n, bad); else passed++;
    total++; if (busy2 !== 1'b0 || tone2 !== 1'b0) $display("FAIL nogap_end: busy/tone got %b%b want 00", busy2, tone2); else passed++;
  endtask

  initial begin
    total = 0; passed = 0;
    rst_n = 1'b0; flush = 1'b0;
    bus.note_valid = 1'b0; bus.note_code = '0; bus.note_octave = '0; bus.note_len = '0;
    bus2.note_valid = 1'b0; bus2.note_code = '0; bus2.note_octave = '0; bus2.note_len = '0;
    test_reset();
    test_single_note();
    test_rest();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_no_gap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
